// File: rtl/slow_tick_receiver.sv
// slow_tick_receiver
//   Consumer end of a slow-clock divider. The divided square wave is brought
//   into the clk domain, each rising edge becomes a one-cycle tick enable, the
//   ticks drive an mm:ss BCD elapsed-time counter, and the spacing between
//   ticks is measured so that bad or stalled slow clocks are flagged.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   slow_in      divided clock, asynchronous to clk, slow and glitch-free
//   enable       1 = ticks advance the time counter
//   clear        synchronous restart: time 00:00, IDLE, sticky flags cleared
//   tick         one-cycle pulse per slow_in rising edge
//   sec_bcd      seconds, two BCD digits, 00-59
//   min_bcd      minutes, two BCD digits, 00-99
//   running      FSM is in RUN
//   stalled      FSM is in STALL
//   period_err   sticky: a measured period was outside EXPECT_PERIOD +/- TOL
//   overflow     sticky: time saturated at 99:59
//   last_period  last valid measured tick-to-tick distance in clk cycles
//
// There is no valid/ready handshake on this block: tick is a plain one-cycle
// strobe and every other output is a level that is valid in every cycle.
module slow_tick_receiver #(
    parameter int EXPECT_PERIOD = 50000000,
    parameter int TOL           = 1000,
    parameter int CNT_W         = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_in,
    input  logic             enable,
    input  logic             clear,
    output logic             tick,
    output logic [7:0]       sec_bcd,
    output logic [7:0]       min_bcd,
    output logic             running,
    output logic             stalled,
    output logic             period_err,
    output logic             overflow,
    output logic [CNT_W-1:0] last_period
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LO_LIM = CNT_W'(EXPECT_PERIOD - TOL);
    localparam logic [CNT_W-1:0] HI_LIM = CNT_W'(EXPECT_PERIOD + TOL);
    // Compared one cycle early so STALL is entered on the same edge at which
    // pcnt becomes 2*EXPECT_PERIOD, i.e. exactly 2*EXPECT_PERIOD cycles after
    // the last tick.
    localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(2 * EXPECT_PERIOD - 1);

    state_t           state;
    state_t           state_next;
    logic             s0, s1, s2;
    logic [CNT_W-1:0] pcnt;
    logic [3:0]       sec_lo, sec_hi, min_lo, min_hi;
    logic             tick_check;
    logic             tick_advance;

    // Synchroniser and edge detector. clear deliberately leaves these alone
    // so an edge already in flight still produces its tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0   <= 1'b0;
            s1   <= 1'b0;
            s2   <= 1'b0;
            tick <= 1'b0;
        end else begin
            s0   <= slow_in;
            s1   <= s0;
            s2   <= s1;
            tick <= s1 & ~s2;
        end
    end

    // FSM state register; clear discards any tick in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick) state_next = RUN;
            RUN:     if (!tick && pcnt >= STALL_AT) state_next = STALL;
            STALL:   if (tick) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs. The arming tick in IDLE neither checks nor advances; the
    // recovery tick in STALL advances but is not period-checked.
    always_comb begin
        running      = (state == RUN);
        stalled      = (state == STALL);
        tick_check   = tick && (state == RUN);
        tick_advance = tick && enable && (state != IDLE);
    end

    // Period counter: restarts at 1 on every tick so its value in a tick
    // cycle is the distance from the previous tick.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= ONE;
        end else if (state == IDLE) begin
            pcnt <= '0;
        end else if (pcnt != {CNT_W{1'b1}}) begin
            pcnt <= pcnt + ONE;
        end
    end

    // Period measurement and sticky range error.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            last_period <= '0;
            period_err  <= 1'b0;
        end else if (tick_check) begin
            last_period <= pcnt;
            if (pcnt < LO_LIM || pcnt > HI_LIM) begin
                period_err <= 1'b1;
            end
        end
    end

    // BCD mm:ss counter, saturating at 99:59.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sec_lo   <= 4'd0;
            sec_hi   <= 4'd0;
            min_lo   <= 4'd0;
            min_hi   <= 4'd0;
            overflow <= 1'b0;
        end else if (tick_advance) begin
            if (min_hi == 4'd9 && min_lo == 4'd9 && sec_hi == 4'd5 && sec_lo == 4'd9) begin
                overflow <= 1'b1;
            end else if (sec_lo != 4'd9) begin
                sec_lo <= sec_lo + 4'd1;
            end else begin
                sec_lo <= 4'd0;
                if (sec_hi != 4'd5) begin
                    sec_hi <= sec_hi + 4'd1;
                end else begin
                    sec_hi <= 4'd0;
                    if (min_lo != 4'd9) begin
                        min_lo <= min_lo + 4'd1;
                    end else begin
                        min_lo <= 4'd0;
                        min_hi <= min_hi + 4'd1;
                    end
                end
            end
        end
    end

    assign sec_bcd = {sec_hi, sec_lo};
    assign min_bcd = {min_hi, min_lo};

endmodule

// File: tb/tb_slow_tick_receiver.sv
// tb_slow_tick_receiver
//   Directed bench for slow_tick_receiver with EXPECT_PERIOD=20, TOL=2,
//   CNT_W=8. Every slow_in pulse is driven high for 5 cycles; pulse_after(p)
//   places the next rising edge exactly p cycles after the previous one, so
//   the tick it produces measures p. Outputs are sampled 1 time unit after
//   the rising clock edge.
module tb_slow_tick_receiver;

    localparam int EP = 20;
    localparam int TL = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          slow_in;
    logic          enable;
    logic          clear;
    logic          tick;
    logic [7:0]    sec_bcd;
    logic [7:0]    min_bcd;
    logic          running;
    logic          stalled;
    logic          period_err;
    logic          overflow;
    logic [CW-1:0] last_period;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_cnt = 0;
    int t0;

    typedef struct {
        int         period;
        logic       en;
        logic [7:0] exp_sec;
        logic [7:0] exp_min;
        logic [7:0] exp_last;
        logic       exp_err;
    } vec_t;

    vec_t vecs[11];

    // clock / reset block
    always #5 clk = ~clk;

    slow_tick_receiver #(
        .EXPECT_PERIOD(EP),
        .TOL(TL),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .slow_in(slow_in),
        .enable(enable),
        .clear(clear),
        .tick(tick),
        .sec_bcd(sec_bcd),
        .min_bcd(min_bcd),
        .running(running),
        .stalled(stalled),
        .period_err(period_err),
        .overflow(overflow),
        .last_period(last_period)
    );

    always @(negedge clk) begin
        if (tick) tick_cnt++;
    end

    // scoreboard compare
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_after(input int p);
        repeat (p - 5) step();
        slow_in = 1'b1;
        repeat (5) step();
        slow_in = 1'b0;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_tick"}, 32'(tick), 0);
        check({tag, "_sec"}, 32'(sec_bcd), 0);
        check({tag, "_min"}, 32'(min_bcd), 0);
        check({tag, "_running"}, 32'(running), 0);
        check({tag, "_stalled"}, 32'(stalled), 0);
        check({tag, "_err"}, 32'(period_err), 0);
        check({tag, "_ovf"}, 32'(overflow), 0);
        check({tag, "_last"}, 32'(last_period), 0);
    endtask

    initial begin
        // Starting from 01:00, last_period 20, no error.
        vecs[0]  = '{20, 1'b1, 8'h01, 8'h01, 8'd20, 1'b0};
        vecs[1]  = '{22, 1'b1, 8'h02, 8'h01, 8'd22, 1'b0};  // upper limit, still ok
        vecs[2]  = '{18, 1'b1, 8'h03, 8'h01, 8'd18, 1'b0};  // lower limit, still ok
        vecs[3]  = '{23, 1'b1, 8'h04, 8'h01, 8'd23, 1'b1};  // too long
        vecs[4]  = '{20, 1'b1, 8'h05, 8'h01, 8'd20, 1'b1};  // sticky
        vecs[5]  = '{17, 1'b1, 8'h06, 8'h01, 8'd17, 1'b1};  // too short, still advances
        vecs[6]  = '{20, 1'b0, 8'h06, 8'h01, 8'd20, 1'b1};  // enable low: time holds
        vecs[7]  = '{21, 1'b0, 8'h06, 8'h01, 8'd21, 1'b1};
        vecs[8]  = '{19, 1'b0, 8'h06, 8'h01, 8'd19, 1'b1};
        vecs[9]  = '{25, 1'b0, 8'h06, 8'h01, 8'd25, 1'b1};
        vecs[10] = '{21, 1'b0, 8'h06, 8'h01, 8'd21, 1'b1};

        rst     = 1'b1;
        slow_in = 1'b0;
        enable  = 1'b1;
        clear   = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) step();

        // First edge: tick exactly in the cycle after the third sampling edge.
        t0 = tick_cnt;
        slow_in = 1'b1;
        step();
        check("t1_tick_e0", 32'(tick), 0);
        step();
        check("t1_tick_e1", 32'(tick), 0);
        step();
        check("t1_tick_e2", 32'(tick), 1);
        check("t1_run_e2", 32'(running), 0);
        step();
        check("t1_tick_e3", 32'(tick), 0);
        check("t1_running", 32'(running), 1);
        check("t1_sec", 32'(sec_bcd), 0);
        step();
        slow_in = 1'b0;

        // 60 nominal periods -> 01:00.
        for (int i = 1; i <= 60; i++) begin
            pulse_after(20);
            check("t2_sec", 32'(sec_bcd), 32'(to_bcd(i % 60)));
            check("t2_min", 32'(min_bcd), 32'(to_bcd(i / 60)));
        end
        check("t2_last", 32'(last_period), 20);
        check("t2_err", 32'(period_err), 0);
        check("t2_ticks", 32'(tick_cnt - t0), 61);

        // Table: tolerance limits, bad periods, enable low.
        for (int k = 0; k < 11; k++) begin
            enable = vecs[k].en;
            pulse_after(vecs[k].period);
            check("tab_sec", 32'(sec_bcd), 32'(vecs[k].exp_sec));
            check("tab_min", 32'(min_bcd), 32'(vecs[k].exp_min));
            check("tab_last", 32'(last_period), 32'(vecs[k].exp_last));
            check("tab_err", 32'(period_err), 32'(vecs[k].exp_err));
        end
        enable = 1'b1;

        // Stall: STALL exactly 40 cycles after the last tick.
        repeat (37) step();
        check("t4_stall_early", 32'(stalled), 0);
        check("t4_run_early", 32'(running), 1);
        step();
        check("t4_stalled", 32'(stalled), 1);
        check("t4_not_run", 32'(running), 0);
        slow_in = 1'b1;
        repeat (5) step();
        slow_in = 1'b0;
        check("t4_recover_run", 32'(running), 1);
        check("t4_recover_stall", 32'(stalled), 0);
        check("t4_recover_sec", 32'(sec_bcd), 32'h07);
        check("t4_recover_last", 32'(last_period), 21);
        pulse_after(20);
        check("t4_next_sec", 32'(sec_bcd), 32'h08);
        check("t4_next_last", 32'(last_period), 20);

        // Clear, then count up to 99:58 with short periods.
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t5_clr_sec", 32'(sec_bcd), 0);
        check("t5_clr_min", 32'(min_bcd), 0);
        check("t5_clr_run", 32'(running), 0);
        check("t5_clr_err", 32'(period_err), 0);
        check("t5_clr_last", 32'(last_period), 0);
        pulse_after(10);
        check("t5_arm_run", 32'(running), 1);
        check("t5_arm_sec", 32'(sec_bcd), 0);
        for (int i = 0; i < 5998; i++) pulse_after(10);
        check("t5_9958_sec", 32'(sec_bcd), 32'h58);
        check("t5_9958_min", 32'(min_bcd), 32'h99);
        check("t5_9958_ovf", 32'(overflow), 0);
        pulse_after(10);
        check("t5_9959_sec", 32'(sec_bcd), 32'h59);
        check("t5_9959_ovf", 32'(overflow), 0);
        pulse_after(10);
        check("t5_sat_sec", 32'(sec_bcd), 32'h59);
        check("t5_sat_min", 32'(min_bcd), 32'h99);
        check("t5_sat_ovf", 32'(overflow), 1);
        check("t5_sat_err", 32'(period_err), 1);

        // Clear in the same cycle as a tick: tick discarded, stays IDLE.
        repeat (5) step();
        slow_in = 1'b1;
        repeat (3) step();
        check("t5_cc_tick", 32'(tick), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t5_cc_sec", 32'(sec_bcd), 0);
        check("t5_cc_min", 32'(min_bcd), 0);
        check("t5_cc_run", 32'(running), 0);
        check("t5_cc_ovf", 32'(overflow), 0);
        check("t5_cc_err", 32'(period_err), 0);
        check("t5_cc_last", 32'(last_period), 0);
        step();
        slow_in = 1'b0;
        check("t5_cc_idle", 32'(running), 0);
        pulse_after(20);
        check("t5_rearm_run", 32'(running), 1);
        check("t5_rearm_sec", 32'(sec_bcd), 0);
        pulse_after(20);
        check("t5_after_sec", 32'(sec_bcd), 32'h01);
        check("t5_after_last", 32'(last_period), 20);

        // Reset mid-period.
        repeat (7) step();
        rst = 1'b1;
        step();
        check_all_zero("t6_rst");
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
